// File: rtl/banco_wr_sched_pkg.sv
// Shared widths and FSM encoding for the Banco write-port scheduler.
package banco_wr_sched_pkg;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NREGS = 16;
  // Clear sequence writes two registers per cycle.
  localparam int NCLR  = NREGS / 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/banco_wr_sched_rr_pick2.sv
// Two-winner round-robin picker: first active requester from ptr wins C, next one with a different dir wins V.
// Purely combinational; en_i low blocks all grants.
module banco_wr_sched_rr_pick2 #(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*AW-1:0] dir_i,
  input  logic [IW-1:0]      ptr_i,
  input  logic               en_i,
  output logic               c_vld_o,
  output logic [IW-1:0]      c_idx_o,
  output logic               v_vld_o,
  output logic [IW-1:0]      v_idx_o,
  output logic [NREQ-1:0]    gnt_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    c_vld_o = 1'b0;
    c_idx_o = '0;
    v_vld_o = 1'b0;
    v_idx_o = '0;
    gnt_o   = '0;
    sum     = '0;
    idx     = '0;
    for (int off = 0; off < NREQ; off++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(off);
      idx = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
      if (en_i && req_i[idx]) begin
        if (!c_vld_o) begin
          c_vld_o = 1'b1;
          c_idx_o = idx;
        end else if (!v_vld_o && (dir_i[idx*AW +: AW] != dir_i[c_idx_o*AW +: AW])) begin
          // A same-address loser keeps scanning so a later requester can still take V.
          v_vld_o = 1'b1;
          v_idx_o = idx;
        end
      end
    end
    if (c_vld_o) gnt_o[c_idx_o] = 1'b1;
    if (v_vld_o) gnt_o[v_idx_o] = 1'b1;
  end

endmodule

// File: rtl/banco_wr_sched.sv
// Banco write-port scheduler: clears all registers after reset, then grants up to two writers per cycle onto ports C/V.
// Grants are same-cycle, commits appear one cycle later; stall blocks grants and drops write enables.
module banco_wr_sched
  import banco_wr_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = banco_wr_sched_pkg::DW,
  parameter int AW   = banco_wr_sched_pkg::AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_dir,
  input  logic [NREQ*DW-1:0] req_din,
  output logic [NREQ-1:0]    gnt,
  input  logic               stall,
  output logic               we_c,
  output logic [AW-1:0]      dir_c,
  output logic [DW-1:0]      din_c,
  output logic               we_v,
  output logic [AW-1:0]      dir_v,
  output logic [DW-1:0]      din_v,
  input  logic [AW-1:0]      rd_dir_a,
  input  logic [AW-1:0]      rd_dir_b,
  output logic               fwd_a_hit,
  output logic [DW-1:0]      fwd_a_data,
  output logic               fwd_b_hit,
  output logic [DW-1:0]      fwd_b_data,
  output logic [NREGS-1:0]   busy_mask,
  output logic               init_done
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(NCLR);

  state_e          state_q;
  logic [CW-1:0]   clr_q;
  logic [IW-1:0]   rr_q, rr_d, last_idx;
  logic            we_c_q, we_v_q, init_done_q;
  logic [AW-1:0]   dir_c_q, dir_v_q;
  logic [DW-1:0]   din_c_q, din_v_q;
  logic            c_vld, v_vld, pick_en;
  logic [IW-1:0]   c_idx, v_idx;

  assign pick_en = (state_q == ST_RUN) && !stall;

  banco_wr_sched_rr_pick2 #(.NREQ(NREQ), .AW(AW), .IW(IW)) u_pick (
    .req_i   (req),
    .dir_i   (req_dir),
    .ptr_i   (rr_q),
    .en_i    (pick_en),
    .c_vld_o (c_vld),
    .c_idx_o (c_idx),
    .v_vld_o (v_vld),
    .v_idx_o (v_idx),
    .gnt_o   (gnt)
  );

  assign last_idx = v_vld ? v_idx : c_idx;
  assign rr_d     = (last_idx == IW'(NREQ-1)) ? '0 : last_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      clr_q       <= '0;
      rr_q        <= '0;
      we_c_q      <= 1'b0;
      we_v_q      <= 1'b0;
      dir_c_q     <= '0;
      dir_v_q     <= '0;
      din_c_q     <= '0;
      din_v_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          we_c_q  <= 1'b1;
          dir_c_q <= AW'(2*clr_q);
          din_c_q <= '0;
          we_v_q  <= 1'b1;
          dir_v_q <= AW'(2*clr_q + 1);
          din_v_q <= '0;
          clr_q   <= clr_q + 1'b1;
          if (clr_q == CW'(NCLR-1)) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          if (stall) begin
            // Commit data holds, but the write must not be replayed.
            we_c_q <= 1'b0;
            we_v_q <= 1'b0;
          end else begin
            we_c_q <= c_vld;
            we_v_q <= v_vld;
            if (c_vld) begin
              dir_c_q <= req_dir[c_idx*AW +: AW];
              din_c_q <= req_din[c_idx*DW +: DW];
              rr_q    <= rr_d;
            end
            if (v_vld) begin
              dir_v_q <= req_dir[v_idx*AW +: AW];
              din_v_q <= req_din[v_idx*DW +: DW];
            end
          end
        end
      endcase
    end
  end

  assign we_c      = we_c_q;
  assign dir_c     = dir_c_q;
  assign din_c     = din_c_q;
  assign we_v      = we_v_q;
  assign dir_v     = dir_v_q;
  assign din_v     = din_v_q;
  assign init_done = init_done_q;

  always_comb begin
    busy_mask = '0;
    if (we_c_q) busy_mask[dir_c_q] = 1'b1;
    if (we_v_q) busy_mask[dir_v_q] = 1'b1;
  end

  // C and V never target the same register, so at most one port matches.
  always_comb begin
    fwd_a_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_hit  = 1'b0;
    fwd_b_data = '0;
    if (init_done_q) begin
      if (we_c_q && dir_c_q == rd_dir_a) begin
        fwd_a_hit  = 1'b1;
        fwd_a_data = din_c_q;
      end else if (we_v_q && dir_v_q == rd_dir_a) begin
        fwd_a_hit  = 1'b1;
        fwd_a_data = din_v_q;
      end
      if (we_c_q && dir_c_q == rd_dir_b) begin
        fwd_b_hit  = 1'b1;
        fwd_b_data = din_c_q;
      end else if (we_v_q && dir_v_q == rd_dir_b) begin
        fwd_b_hit  = 1'b1;
        fwd_b_data = din_v_q;
      end
    end
  end

endmodule

// File: tb/tb_banco_wr_sched.sv
// Self-checking bench for banco_wr_sched: directed scenarios plus random traffic against a queue-based grant model and a bank image.
module tb_banco_wr_sched;

  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_dir;
  logic [NREQ*DW-1:0] req_din;
  logic [NREQ-1:0]    gnt;
  logic               stall;
  logic               we_c, we_v;
  logic [AW-1:0]      dir_c, dir_v;
  logic [DW-1:0]      din_c, din_v;
  logic [AW-1:0]      rd_dir_a, rd_dir_b;
  logic               fwd_a_hit, fwd_b_hit;
  logic [DW-1:0]      fwd_a_data, fwd_b_data;
  logic [15:0]        busy_mask;
  logic               init_done;

  banco_wr_sched #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dir(req_dir), .req_din(req_din), .gnt(gnt),
    .stall(stall), .we_c(we_c), .dir_c(dir_c), .din_c(din_c), .we_v(we_v), .dir_v(dir_v),
    .din_v(din_v), .rd_dir_a(rd_dir_a), .rd_dir_b(rd_dir_b), .fwd_a_hit(fwd_a_hit),
    .fwd_a_data(fwd_a_data), .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
    .busy_mask(busy_mask), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Image of the physical bank, written by whatever the DUT drives onto C/V.
  logic [DW-1:0] bank [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 16; r++) bank[r] <= 32'hBAD0_0000 | DW'(r);
    end else begin
      if (we_c) bank[dir_c] <= din_c;
      if (we_v) bank[dir_v] <= din_v;
    end
  end

  // Requester side: one pending write per requester.
  bit            rq_v   [NREQ];
  logic [AW-1:0] rq_dir [NREQ];
  logic [DW-1:0] rq_din [NREQ];

  // Reference model state.
  int            m_rr;
  bit            m_wc, m_wv;
  logic [AW-1:0] m_dc, m_dv;
  logic [DW-1:0] m_xc, m_xv;
  logic [DW-1:0] ref_rf [16];

  logic [NREQ-1:0] obs_gnt;
  logic            obs_fa_hit, obs_fb_hit;
  logic [DW-1:0]   obs_fa_dat, obs_fb_dat;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setreq(input int i, input logic [AW-1:0] d, input logic [DW-1:0] x);
    rq_v[i]   = 1'b1;
    rq_dir[i] = d;
    rq_din[i] = x;
  endtask

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      req[i]              = rq_v[i];
      req_dir[i*AW +: AW] = rq_dir[i];
      req_din[i*DW +: DW] = rq_din[i];
    end
  endtask

  // One RUN cycle: check same-cycle grant and forwarding, then the commit after the edge.
  task automatic cycle();
    int order[$];
    int c, v;
    logic [NREQ-1:0] eg;
    bit eh;
    logic [DW-1:0] ed;
    pack();
    #1;
    c = -1; v = -1; eg = '0;
    if (!stall) begin
      for (int k = 0; k < NREQ; k++)
        if (rq_v[(m_rr + k) % NREQ]) order.push_back((m_rr + k) % NREQ);
      if (order.size() > 0) begin
        c = order[0];
        for (int k = 1; k < order.size(); k++)
          if (v < 0 && rq_dir[order[k]] != rq_dir[c]) v = order[k];
      end
    end
    if (c >= 0) eg[c] = 1'b1;
    if (v >= 0) eg[v] = 1'b1;
    obs_gnt = gnt;
    obs_fa_hit = fwd_a_hit; obs_fa_dat = fwd_a_data;
    obs_fb_hit = fwd_b_hit; obs_fb_dat = fwd_b_data;
    chk("gnt", 64'(gnt), 64'(eg));
    eh = (m_wc && m_dc == rd_dir_a) || (m_wv && m_dv == rd_dir_a);
    ed = (m_wc && m_dc == rd_dir_a) ? m_xc : m_xv;
    chk("fwd_a_hit", 64'(fwd_a_hit), 64'(eh));
    if (eh) chk("fwd_a_data", 64'(fwd_a_data), 64'(ed));
    eh = (m_wc && m_dc == rd_dir_b) || (m_wv && m_dv == rd_dir_b);
    ed = (m_wc && m_dc == rd_dir_b) ? m_xc : m_xv;
    chk("fwd_b_hit", 64'(fwd_b_hit), 64'(eh));
    if (eh) chk("fwd_b_data", 64'(fwd_b_data), 64'(ed));
    m_wc = (c >= 0);
    m_wv = (v >= 0);
    if (c >= 0) begin
      m_dc = rq_dir[c]; m_xc = rq_din[c]; ref_rf[m_dc] = m_xc; rq_v[c] = 1'b0;
      m_rr = ((v >= 0 ? v : c) + 1) % NREQ;
    end
    if (v >= 0) begin
      m_dv = rq_dir[v]; m_xv = rq_din[v]; ref_rf[m_dv] = m_xv; rq_v[v] = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("we_c", 64'(we_c), 64'(m_wc));
    chk("we_v", 64'(we_v), 64'(m_wv));
    if (m_wc) begin
      chk("dir_c", 64'(dir_c), 64'(m_dc));
      chk("din_c", 64'(din_c), 64'(m_xc));
    end
    if (m_wv) begin
      chk("dir_v", 64'(dir_v), 64'(m_dv));
      chk("din_v", 64'(din_v), 64'(m_xv));
    end
    chk("busy_mask", 64'(busy_mask),
        64'((m_wc ? (16'h1 << m_dc) : 16'h0) | (m_wv ? (16'h1 << m_dv) : 16'h0)));
  endtask

  // Clear sequence right after reset release; requests and stall must be ignored.
  task automatic init_seq();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) setreq(i, AW'(i), DW'(32'h1000 + i));
      stall    = k[0];
      rd_dir_a = AW'(2*k);
      pack();
      #1;
      chk("init_gnt", 64'(gnt), 64'(0));
      @(posedge clk);
      #1;
      chk("init_we_c", 64'(we_c), 64'(1));
      chk("init_dir_c", 64'(dir_c), 64'(2*k));
      chk("init_din_c", 64'(din_c), 64'(0));
      chk("init_we_v", 64'(we_v), 64'(1));
      chk("init_dir_v", 64'(dir_v), 64'(2*k + 1));
      chk("init_din_v", 64'(din_v), 64'(0));
      chk("init_done", 64'(init_done), 64'(k == 7));
      chk("init_fwd_a", 64'(fwd_a_hit), 64'(k == 7));
    end
    for (int i = 0; i < NREQ; i++) rq_v[i] = 1'b0;
    stall = 1'b0;
    pack();
    m_rr = 0;
    m_wc = 1'b1; m_dc = 4'd14; m_xc = '0;
    m_wv = 1'b1; m_dv = 4'd15; m_xv = '0;
    for (int r = 0; r < 16; r++) ref_rf[r] = '0;
  endtask

  task automatic rand_cycles(input int n);
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < NREQ; i++)
        if (!rq_v[i] && $urandom_range(0, 1) == 1)
          setreq(i, AW'($urandom_range(0, 15)), DW'($urandom));
      stall    = ($urandom_range(0, 7) == 0);
      rd_dir_a = ($urandom_range(0, 3) == 0) ? m_dc : AW'($urandom_range(0, 15));
      rd_dir_b = ($urandom_range(0, 3) == 0) ? m_dv : AW'($urandom_range(0, 15));
      cycle();
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; rd_dir_a = '0; rd_dir_b = '0;
    for (int i = 0; i < NREQ; i++) setreq(i, AW'(i), DW'(i));
    pack();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_we_c", 64'(we_c), 64'(0));
    chk("rst_we_v", 64'(we_v), 64'(0));
    chk("rst_dir_c", 64'(dir_c), 64'(0));
    chk("rst_din_v", 64'(din_v), 64'(0));
    chk("rst_busy", 64'(busy_mask), 64'(0));
    chk("rst_init_done", 64'(init_done), 64'(0));
    rst = 1'b0;
    init_seq();

    // Single request.
    setreq(0, 4'd5, 32'hDEADBEEF);
    cycle();
    chk("single_gnt", 64'(obs_gnt), 64'(4'b0001));
    chk("single_dir_c", 64'(dir_c), 64'(5));
    chk("single_we_v", 64'(we_v), 64'(0));
    chk("single_busy", 64'(busy_mask), 64'(16'h0020));
    for (int r = 0; r < 16; r++) chk("cleared_reg", 64'(bank[r]), 64'(0));

    // Move the pointer back to 0, then a dual grant.
    setreq(3, 4'd12, 32'h33);
    cycle();
    setreq(0, 4'd3, 32'h11);
    setreq(2, 4'd9, 32'h22);
    cycle();
    chk("dual_gnt", 64'(obs_gnt), 64'(4'b0101));
    chk("dual_c", 64'({dir_c, din_c}), 64'({4'd3, 32'h11}));
    chk("dual_v", 64'({dir_v, din_v}), 64'({4'd9, 32'h22}));

    // Pointer now at 3: r3 must take C ahead of r0; also forward from port V.
    rd_dir_a = 4'd9;
    setreq(0, 4'd1, 32'h44);
    setreq(3, 4'd2, 32'h55);
    cycle();
    chk("fwdv_hit", 64'(obs_fa_hit), 64'(1));
    chk("fwdv_data", 64'(obs_fa_dat), 64'(32'h22));
    chk("ptr3_gnt", 64'(obs_gnt), 64'(4'b1001));
    chk("ptr3_dir_c", 64'(dir_c), 64'(2));
    chk("ptr3_dir_v", 64'(dir_v), 64'(1));

    // Same-address conflict.
    setreq(1, 4'd7, 32'h71);
    setreq(3, 4'd7, 32'h73);
    cycle();
    chk("conf_gnt1", 64'(obs_gnt), 64'(4'b0010));
    chk("conf_we_v", 64'(we_v), 64'(0));
    cycle();
    chk("conf_gnt2", 64'(obs_gnt), 64'(4'b1000));
    chk("conf_c", 64'({dir_c, din_c}), 64'({4'd7, 32'h73}));

    // Fairness with all four requesting continuously.
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < NREQ; i++)
        if (!rq_v[i]) setreq(i, AW'(10 + i), DW'(32'hF00 + 16*s + i));
      cycle();
      chk("fair_gnt", 64'(obs_gnt), 64'((s == 1) ? 4'b1100 : 4'b0011));
    end
    for (int i = 0; i < NREQ; i++) rq_v[i] = 1'b0;
    cycle();

    // Forward + stall.
    setreq(2, 4'd4, 32'hCAFE);
    cycle();
    rd_dir_b = 4'd4;
    stall    = 1'b1;
    setreq(1, 4'd6, 32'h66);
    cycle();
    chk("stall_fwd_b_hit", 64'(obs_fb_hit), 64'(1));
    chk("stall_fwd_b_data", 64'(obs_fb_dat), 64'(32'hCAFE));
    chk("stall_gnt", 64'(obs_gnt), 64'(0));
    chk("stall_we_c", 64'(we_c), 64'(0));
    stall = 1'b0;
    cycle();
    chk("post_stall_gnt", 64'(obs_gnt), 64'(4'b0010));

    rand_cycles(400);

    // Reset with a commit in flight and requests pending.
    for (int i = 0; i < NREQ; i++) setreq(i, AW'(i + 2), DW'(32'h5A00 + i));
    stall = 1'b0;
    cycle();
    rst = 1'b1;
    pack();
    @(posedge clk);
    #1;
    chk("mid_rst_we_c", 64'(we_c), 64'(0));
    chk("mid_rst_we_v", 64'(we_v), 64'(0));
    chk("mid_rst_busy", 64'(busy_mask), 64'(0));
    chk("mid_rst_init_done", 64'(init_done), 64'(0));
    chk("mid_rst_gnt", 64'(gnt), 64'(0));
    rst = 1'b0;
    init_seq();

    rand_cycles(150);
    for (int i = 0; i < NREQ; i++) rq_v[i] = 1'b0;
    stall = 1'b0;
    repeat (2) cycle();
    for (int r = 0; r < 16; r++) chk("bank_final", 64'(bank[r]), 64'(ref_rf[r]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
